fetch_wide: RTL and testbench
=============================

FETCH_WIDE -- requirements
Module: fetch_wide

Interface
REQ-001 Parameter FETCH_WIDTH, default 2, instructions fetched/presented per cycle; legal values 1 or 2.
REQ-002 Parameter BUF_DEPTH, default 8, instruction-buffer entries; power of two, >= 2*FETCH_WIDTH.
REQ-003 Parameter RESET_PC, default 0, PC loaded at reset; 4-byte aligned.
REQ-004 clock  in  1  sole clock; all state updates on posedge.
REQ-005 reset  in  1  asynchronous, active-low reset (asserted when 0).
REQ-006 redirect_valid  in  1  branch-mispredict redirect from CDB.
REQ-007 redirect_pc  in  XLEN  redirect target, 4-byte aligned.
REQ-008 Icache2proc_data  in  64  two instructions; [31:0] at addr, [63:32] at addr+4.
REQ-009 Icache2proc_valid  in  1  Icache2proc_data valid for proc2Icache_addr this cycle.
REQ-010 proc2Icache_addr  out  XLEN  {PC[XLEN-1:3],3'b0}.
REQ-011 deq_count  in  $clog2(FETCH_WIDTH+1)  entries dispatch consumes this cycle.
REQ-012 if_packet_out  out  FETCH_PACKET[FETCH_WIDTH]  buffer head entries; slot 0 oldest.
REQ-013 avail_count  out  $clog2(FETCH_WIDTH+1)  min(occupancy, FETCH_WIDTH).
REQ-014 buf_full  out  1  occupancy == BUF_DEPTH.

Function
REQ-015 Enqueue group: FETCH_WIDTH=2 and PC[2]=0 -> words 0,1 (PCs PC, PC+4), PC+=8; otherwise one word selected by PC[2], PC+=4.
REQ-016 Enqueue occurs only if Icache2proc_valid=1, redirect_valid=0, and free entries (BUF_DEPTH minus pre-dequeue occupancy) >= group size; all-or-nothing; else PC holds.
REQ-017 Each entry: valid=1, inst, PC, NPC=PC+4.
REQ-018 Buffer is a circular FIFO; head/tail wrap modulo BUF_DEPTH; occupancy(next)=occupancy+enq-deq.
REQ-019 Simultaneous enqueue and dequeue allowed; freed slots not reusable in same cycle.
REQ-020 deq_count > avail_count saturates to avail_count.
REQ-021 Latency: group enqueued at edge t is visible on if_packet_out after edge t (one cycle, registered state, no combinational Icache-to-output path).
REQ-022 if_packet_out[i].valid = (i < avail_count); invalid slots drive inst=0, PC=0, NPC=0.
REQ-023 redirect_valid=1: next state PC=redirect_pc, occupancy=0, head=tail=0; enqueue and dequeue that cycle suppressed; redirect has priority over all events.
REQ-024 Empty buffer: avail_count=0, dequeue ignored; full buffer: no enqueue, PC holds.

Reset
REQ-025 While reset=0: PC=RESET_PC, head=tail=occupancy=0, all if_packet_out valid=0, avail_count=0, buf_full=0, proc2Icache_addr={RESET_PC[XLEN-1:3],3'b0}.
REQ-026 Reset asserted mid-operation discards all buffered instructions immediately, without waiting for a clock edge.

Configuration
REQ-027 Macro FETCH_PERF_EN defined: extra outputs fetch_count (32b, instructions enqueued) and stall_count (32b, cycles with Icache2proc_valid=0 or enqueue blocked by space, redirect cycles excluded), both saturating, reset to 0.
REQ-028 FETCH_PERF_EN undefined: those ports and counters absent; all other behaviour identical.

Structure
REQ-029 FETCH_PACKET (valid, inst, PC, NPC), FETCH_WIDTH and FETCH_BUF_DEPTH defaults belong in the shared header package.
REQ-030 Circular queue is sub-module fetch_buffer (enq/deq counts, flush, head window); fetch_wide holds PC, group logic, redirect.

Verification
REQ-031 Reset, Icache valid, data 64'h00A0_0013_0010_0093, no dequeue -> after 1 edge slot0 PC 0 inst 00100093, slot1 PC 4 inst 00A00013, address 8.
REQ-032 No dequeue, Icache always valid, BUF_DEPTH=8 -> buf_full=1 after 4 edges; PC holds at 0x20.
REQ-033 Redirect to 0x104 with 6 entries buffered, deq_count=2 -> next cycle avail_count=0, address 0x100; following cycle one instruction, PC 0x104.
REQ-034 Icache2proc_valid=0 for 3 cycles -> no enqueue, PC unchanged; with FETCH_PERF_EN stall_count=3.
REQ-035 Occupancy 7, deq_count=2, group of 2 arriving -> enqueue blocked (free=1), occupancy 5.
REQ-036 reset driven 0 asynchronously between edges with 4 entries -> avail_count=0 before next posedge.

Source files
------------

// File: rtl/fetch_wide_pkg.sv
// Shared types and defaults for the wide fetch stage.
// Holds the fetch packet layout and the default widths and depths used by
// fetch_wide and fetch_buffer.
package fetch_wide_pkg;

  localparam int XLEN            = 32;
  localparam int DEF_FETCH_WIDTH = 2;
  localparam int FETCH_BUF_DEPTH = 8;

  // One fetched instruction as presented to dispatch
  typedef struct packed {
    logic            valid;
    logic [31:0]     inst;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] npc;
  } FETCH_PACKET;

  // Icache requests are always for the aligned 8-byte line holding the PC
  function automatic logic [XLEN-1:0] line_addr(input logic [XLEN-1:0] pc);
    return {pc[XLEN-1:3], 3'b000};
  endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Circular instruction buffer between fetch and dispatch.
// Accepts up to WIDTH entries per cycle at the tail, releases up to WIDTH
// entries per cycle from the head, and exposes the WIDTH oldest entries.
// The caller guarantees enq_count never exceeds the free space it sees.
module fetch_buffer
  import fetch_wide_pkg::*;
#(
  parameter int DEPTH = FETCH_BUF_DEPTH,
  parameter int WIDTH = DEF_FETCH_WIDTH,
  parameter int CW    = $clog2(WIDTH + 1),
  parameter int OW    = $clog2(DEPTH + 1)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  input  logic [CW-1:0]     enq_count,
  input  FETCH_PACKET       enq_data [WIDTH],
  input  logic [CW-1:0]     deq_count,
  output FETCH_PACKET       head_out [WIDTH],
  output logic [CW-1:0]     avail_count,
  output logic [OW-1:0]     free_count,
  output logic              full
);

  localparam int PW = $clog2(DEPTH);

  FETCH_PACKET mem_q [DEPTH];
  FETCH_PACKET mem_d [DEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [OW-1:0] occ_q, occ_d;
  logic [CW-1:0] deq_eff;

  // Status flags and the read window at the head, all from registered state
  always_comb begin
    logic [PW-1:0] rd_idx;
    avail_count = (occ_q >= OW'(WIDTH)) ? CW'(WIDTH) : CW'(occ_q);
    free_count  = OW'(DEPTH) - occ_q;
    full        = (occ_q == OW'(DEPTH));
    deq_eff     = (deq_count > avail_count) ? avail_count : deq_count;
    for (int i = 0; i < WIDTH; i++) begin
      rd_idx      = head_q + PW'(i);
      head_out[i] = '0;
      if (CW'(i) < avail_count) begin
        head_out[i]       = mem_q[rd_idx];
        head_out[i].valid = 1'b1;
      end
    end
  end

  // Next pointers, occupancy and storage; a flush empties the buffer outright
  always_comb begin
    logic [PW-1:0] wr_idx;
    mem_d  = mem_q;
    head_d = head_q;
    tail_d = tail_q;
    occ_d  = occ_q;
    wr_idx = '0;
    if (flush) begin
      head_d = '0;
      tail_d = '0;
      occ_d  = '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        wr_idx = tail_q + PW'(i);
        if (CW'(i) < enq_count) begin
          mem_d[wr_idx] = enq_data[i];
        end
      end
      tail_d = tail_q + PW'(enq_count);
      head_d = head_q + PW'(deq_eff);
      occ_d  = occ_q + OW'(enq_count) - OW'(deq_eff);
    end
  end

  // Buffer state register; reset discards everything immediately
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      occ_q  <= occ_d;
      mem_q  <= mem_d;
    end
  end

endmodule

// File: rtl/fetch_wide.sv
// Wide instruction fetch stage: PC, fetch group selection, redirect handling.
// Fetches one or two instructions per cycle from a 64-bit Icache line into
// fetch_buffer. Define FETCH_PERF_EN to add the fetch_count / stall_count
// performance counters.
module fetch_wide
  import fetch_wide_pkg::*;
#(
  parameter int FETCH_WIDTH = DEF_FETCH_WIDTH,
  parameter int BUF_DEPTH   = FETCH_BUF_DEPTH,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int CW = $clog2(FETCH_WIDTH + 1)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              redirect_valid,
  input  logic [XLEN-1:0]   redirect_pc,
  input  logic [63:0]       Icache2proc_data,
  input  logic              Icache2proc_valid,
  output logic [XLEN-1:0]   proc2Icache_addr,
  input  logic [CW-1:0]     deq_count,
  output FETCH_PACKET       if_packet_out [FETCH_WIDTH],
  output logic [CW-1:0]     avail_count,
  output logic              buf_full
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]       fetch_count,
  output logic [31:0]       stall_count
`endif
);

  localparam int OW = $clog2(BUF_DEPTH + 1);

  logic [XLEN-1:0] pc_q, pc_d;
  logic            grp_two;
  logic [CW-1:0]   grp_size;
  logic            space_ok;
  logic            enq_ok;
  logic [CW-1:0]   enq_count;
  FETCH_PACKET     enq_data [FETCH_WIDTH];
  logic [OW-1:0]   free_count;

  // Choose the fetch group from the PC and decide whether it can be enqueued
  always_comb begin
    grp_two  = (FETCH_WIDTH == 2) && !pc_q[2];
    grp_size = grp_two ? CW'(2) : CW'(1);
    space_ok = free_count >= OW'(grp_size);
    enq_ok   = Icache2proc_valid && !redirect_valid && space_ok;
    enq_count = enq_ok ? grp_size : '0;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      enq_data[i] = '0;
    end
    enq_data[0].valid = 1'b1;
    enq_data[0].pc    = pc_q;
    enq_data[0].npc   = pc_q + XLEN'(4);
    enq_data[0].inst  = pc_q[2] ? Icache2proc_data[63:32] : Icache2proc_data[31:0];
    if (grp_two) begin
      enq_data[FETCH_WIDTH-1].valid = 1'b1;
      enq_data[FETCH_WIDTH-1].pc    = pc_q + XLEN'(4);
      enq_data[FETCH_WIDTH-1].npc   = pc_q + XLEN'(8);
      enq_data[FETCH_WIDTH-1].inst  = Icache2proc_data[63:32];
    end
  end

  // Next PC: redirect wins, otherwise advance past an accepted group
  always_comb begin
    pc_d = pc_q;
    if (redirect_valid) begin
      pc_d = redirect_pc;
    end else if (enq_ok) begin
      pc_d = grp_two ? pc_q + XLEN'(8) : pc_q + XLEN'(4);
    end
    proc2Icache_addr = line_addr(pc_q);
  end

  // PC register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  fetch_buffer #(
    .DEPTH (BUF_DEPTH),
    .WIDTH (FETCH_WIDTH)
  ) u_buffer (
    .clock       (clock),
    .reset       (reset),
    .flush       (redirect_valid),
    .enq_count   (enq_count),
    .enq_data    (enq_data),
    .deq_count   (deq_count),
    .head_out    (if_packet_out),
    .avail_count (avail_count),
    .free_count  (free_count),
    .full        (buf_full)
  );

`ifdef FETCH_PERF_EN
  logic [31:0] fetch_count_q, fetch_count_d;
  logic [31:0] stall_count_q, stall_count_d;

  // Saturating counts of enqueued instructions and stalled non-redirect cycles
  always_comb begin
    fetch_count_d = fetch_count_q;
    stall_count_d = stall_count_q;
    if (enq_ok && fetch_count_q <= 32'hFFFF_FFFF - 32'(grp_size)) begin
      fetch_count_d = fetch_count_q + 32'(grp_size);
    end else if (enq_ok) begin
      fetch_count_d = 32'hFFFF_FFFF;
    end
    if (!redirect_valid && (!Icache2proc_valid || !space_ok) &&
        stall_count_q != 32'hFFFF_FFFF) begin
      stall_count_d = stall_count_q + 32'd1;
    end
  end

  // Performance counter registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fetch_count_q <= '0;
      stall_count_q <= '0;
    end else begin
      fetch_count_q <= fetch_count_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign fetch_count = fetch_count_q;
  assign stall_count = stall_count_q;
`endif

endmodule

// File: tb/tb_fetch_wide.sv
// Self-checking bench for fetch_wide: directed scenarios followed by random
// traffic, checked against a queue-based model of the fetch stage.
module tb_fetch_wide;
  import fetch_wide_pkg::*;

  localparam int FW    = 2;
  localparam int DEPTH = 8;

  logic            clock;
  logic            reset;
  logic            redirect_valid;
  logic [31:0]     redirect_pc;
  logic [63:0]     Icache2proc_data;
  logic            Icache2proc_valid;
  logic [31:0]     proc2Icache_addr;
  logic [1:0]      deq_count;
  FETCH_PACKET     if_packet_out [FW];
  logic [1:0]      avail_count;
  logic            buf_full;
`ifdef FETCH_PERF_EN
  logic [31:0]     fetch_count;
  logic [31:0]     stall_count;
`endif

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] mpc;
  int unsigned m_fetch;
  int unsigned m_stall;
  int          checks;
  int          fails;

  fetch_wide #(
    .FETCH_WIDTH (FW),
    .BUF_DEPTH   (DEPTH),
    .RESET_PC    (32'h0)
  ) dut (
    .clock             (clock),
    .reset             (reset),
    .redirect_valid    (redirect_valid),
    .redirect_pc       (redirect_pc),
    .Icache2proc_data  (Icache2proc_data),
    .Icache2proc_valid (Icache2proc_valid),
    .proc2Icache_addr  (proc2Icache_addr),
    .deq_count         (deq_count),
    .if_packet_out     (if_packet_out),
    .avail_count       (avail_count),
    .buf_full          (buf_full)
`ifdef FETCH_PERF_EN
    ,
    .fetch_count       (fetch_count),
    .stall_count       (stall_count)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Pretend instruction memory: a word is a scrambled copy of its address
  function automatic logic [31:0] memWord(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  function automatic logic [63:0] lineData();
    logic [31:0] base;
    base = {mpc[31:3], 3'b000};
    return {memWord(base + 32'd4), memWord(base)};
  endfunction

  task automatic checkVal(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    mq.delete();
    mpc     = 32'h0;
    m_fetch = 0;
    m_stall = 0;
  endtask

  // One clock of the fetch stage as described by its rules
  task automatic modelStep(input logic rv, input logic [31:0] rpc, input logic iv,
                           input logic [63:0] data, input int deq);
    int avail, d, size, free;
    logic enq;
    if (rv) begin
      mq.delete();
      mpc = rpc;
      return;
    end
    avail = (mq.size() < FW) ? mq.size() : FW;
    d     = (deq < avail) ? deq : avail;
    size  = (FW == 2 && mpc[2] == 1'b0) ? 2 : 1;
    free  = DEPTH - mq.size();
    enq   = iv && (free >= size);
    if (!iv || free < size) m_stall++;
    for (int k = 0; k < d; k++) void'(mq.pop_front());
    if (enq) begin
      for (int k = 0; k < size; k++) begin
        logic [31:0] a;
        a = mpc + 32'(4 * k);
        mq.push_back('{inst: (a[2] ? data[63:32] : data[31:0]), pc: a});
      end
      mpc = mpc + 32'(4 * size);
      m_fetch += size;
    end
  endtask

  task automatic checkOutput();
    int av;
    FETCH_PACKET ep;
    av = (mq.size() < FW) ? mq.size() : FW;
    checkVal("avail_count", 128'(avail_count), 128'(av));
    checkVal("buf_full", 128'(buf_full), 128'(mq.size() == DEPTH));
    checkVal("icache_addr", 128'(proc2Icache_addr), 128'({mpc[31:3], 3'b000}));
    for (int i = 0; i < FW; i++) begin
      ep = '0;
      if (i < av) begin
        ep.valid = 1'b1;
        ep.inst  = mq[i].inst;
        ep.pc    = mq[i].pc;
        ep.npc   = mq[i].pc + 32'd4;
      end
      checkVal($sformatf("slot%0d", i), 128'(if_packet_out[i]), 128'(ep));
    end
`ifdef FETCH_PERF_EN
    checkVal("fetch_count", 128'(fetch_count), 128'(m_fetch));
    checkVal("stall_count", 128'(stall_count), 128'(m_stall));
`endif
  endtask

  task automatic applyStimulus(input logic rv, input logic [31:0] rpc, input logic iv,
                               input logic [63:0] data, input int deq);
    redirect_valid    = rv;
    redirect_pc       = rpc;
    Icache2proc_valid = iv;
    Icache2proc_data  = data;
    deq_count         = 2'(deq);
    modelStep(rv, rpc, iv, data, deq);
    @(posedge clock);
    @(negedge clock);
    checkOutput();
  endtask

  initial begin
    checks = 0;
    fails  = 0;
    reset             = 1'b0;
    redirect_valid    = 1'b0;
    redirect_pc       = '0;
    Icache2proc_valid = 1'b0;
    Icache2proc_data  = '0;
    deq_count         = '0;
    modelReset();
    repeat (2) @(negedge clock);
    checkOutput();
    reset = 1'b1;

    // First line: two instructions appear one edge later
    applyStimulus(1'b0, 32'h0, 1'b1, 64'h00A0_0013_0010_0093, 0);
    checkVal("first_slot0_inst", 128'(if_packet_out[0].inst), 128'(32'h0010_0093));
    checkVal("first_slot0_pc", 128'(if_packet_out[0].pc), 128'(32'h0));
    checkVal("first_slot1_inst", 128'(if_packet_out[1].inst), 128'(32'h00A0_0013));
    checkVal("first_slot1_pc", 128'(if_packet_out[1].pc), 128'(32'h4));
    checkVal("first_addr", 128'(proc2Icache_addr), 128'(32'h8));

    // Fill to full with no dequeue, then confirm the PC holds
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 32'h0, 1'b1, lineData(), 0);
    checkVal("full_flag", 128'(buf_full), 128'(1'b1));
    checkVal("full_addr", 128'(proc2Icache_addr), 128'(32'h20));
    applyStimulus(1'b0, 32'h0, 1'b1, lineData(), 0);
    checkVal("full_hold_addr", 128'(proc2Icache_addr), 128'(32'h20));

    // Drain to 6 entries, then redirect to 0x104 while dequeuing
    applyStimulus(1'b0, 32'h0, 1'b0, 64'h0, 2);
    applyStimulus(1'b1, 32'h104, 1'b1, lineData(), 2);
    checkVal("redir_avail", 128'(avail_count), 128'(0));
    checkVal("redir_addr", 128'(proc2Icache_addr), 128'(32'h100));
    applyStimulus(1'b0, 32'h0, 1'b1, lineData(), 0);
    checkVal("redir_one_avail", 128'(avail_count), 128'(1));
    checkVal("redir_one_pc", 128'(if_packet_out[0].pc), 128'(32'h104));

    // Icache not valid for three cycles
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 32'h0, 1'b0, 64'hDEAD_BEEF_0BAD_F00D, 0);
    checkVal("stall_addr", 128'(proc2Icache_addr), 128'(32'h108));

    // Build occupancy 7, then a two-wide group must be refused even with dequeue
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 32'h0, 1'b1, lineData(), 0);
    checkVal("occ7_addr", 128'(proc2Icache_addr), 128'(32'h120));
    applyStimulus(1'b0, 32'h0, 1'b1, lineData(), 2);
    checkVal("blocked_addr", 128'(proc2Icache_addr), 128'(32'h120));

    // Four entries buffered, then reset asserted between edges
    applyStimulus(1'b1, 32'h0, 1'b0, 64'h0, 0);
    for (int i = 0; i < 2; i++) applyStimulus(1'b0, 32'h0, 1'b1, lineData(), 0);
    #2 reset = 1'b0;
    #1;
    modelReset();
    checkVal("async_reset_avail", 128'(avail_count), 128'(0));
    checkOutput();
    @(negedge clock);
    reset = 1'b1;

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      logic rv, iv;
      logic [31:0] rpc;
      rv  = ($urandom_range(0, 19) == 0);
      rpc = {20'h0, 10'($urandom_range(0, 1023)), 2'b00};
      iv  = ($urandom_range(0, 9) < 7);
      applyStimulus(rv, rpc, iv, iv ? lineData() : {$urandom, $urandom},
                    int'($urandom_range(0, 2)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
